// File: rtl/score_display_pkg.sv
// score_display_pkg: shared 7-segment/anode patterns and the BCD increment helper
package score_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [9:0][6:0] SEG_DIGIT = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                             SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

    localparam logic [3:0]      AN_OFF = 4'b1111;
    localparam logic [3:0][3:0] AN_SEL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    localparam logic [15:0] SCORE_MAX = 16'h9999;

    // Ripple the +1 carry through the four BCD digits, wrapping 9 to 0.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (c) begin
                if (r[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/score_display_bcd_to_7seg.sv
// bcd_to_7seg: BCD digit to active-low {g,f,e,d,c,b,a} segments, blank for 10-15
module bcd_to_7seg
    import score_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Non-decimal codes blank the digit rather than show garbage.
    always_comb begin
        o_seg = (i_bcd <= 4'd9) ? SEG_DIGIT[i_bcd] : SEG_BLANK;
    end

endmodule

// File: rtl/score_display.sv
// score_display: counts rising bullet_hit bits into a saturating BCD score and scans it onto a 4-digit display
module score_display
    import score_display_pkg::*;
#(
    parameter int HIT_WIDTH = 8,
    parameter int SCAN_BITS = 17,
    parameter int PEND_BITS = 4
) (
    input  logic                 clk25,
    input  logic                 rst_n,
    input  logic [HIT_WIDTH-1:0] bullet_hit,
    input  logic                 clear,
    output logic [15:0]          score_bcd,
    output logic                 score_max,
    output logic [3:0]           an,
    output logic [6:0]           seg,
    output logic                 dp
);

    localparam int CNT_W = $clog2(HIT_WIDTH + 1);
    localparam int SUM_W = ((PEND_BITS > CNT_W) ? PEND_BITS : CNT_W) + 1;
    localparam logic [PEND_BITS-1:0] PEND_MAX = '1;

    logic [HIT_WIDTH-1:0] r_hit_prev;
    logic [PEND_BITS-1:0] r_pending;
    logic [15:0]          r_score;
    logic                 r_score_max;
    logic [SCAN_BITS-1:0] r_scan;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;

    logic [HIT_WIDTH-1:0] w_rise;
    logic [CNT_W-1:0]     w_new_hits;
    logic                 w_drain;
    logic [SUM_W-1:0]     w_sum;
    logic [PEND_BITS-1:0] w_pend_next;
    logic [15:0]          w_score_next;
    logic [1:0]           w_sel;
    logic [3:0]           w_digit;
    logic [6:0]           w_seg;

    // Count new hits and work out the next pending count and score; one pending hit drains per cycle.
    always_comb begin
        w_rise     = bullet_hit & ~r_hit_prev;
        w_new_hits = '0;
        for (int i = 0; i < HIT_WIDTH; i++) begin
            w_new_hits = w_new_hits + CNT_W'(w_rise[i]);
        end
        w_drain      = (r_pending != '0);
        w_sum        = SUM_W'(r_pending) + SUM_W'(w_new_hits) - SUM_W'(w_drain);
        w_pend_next  = (w_sum > SUM_W'(PEND_MAX)) ? PEND_MAX : w_sum[PEND_BITS-1:0];
        w_score_next = (w_drain && r_score != SCORE_MAX) ? bcd_inc(r_score) : r_score;
    end

    // Hit tracking and score state; clear overrides any hits in the same cycle.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_prev  <= '0;
            r_pending   <= '0;
            r_score     <= '0;
            r_score_max <= 1'b0;
        end else if (clear) begin
            r_hit_prev  <= '0;
            r_pending   <= '0;
            r_score     <= '0;
            r_score_max <= 1'b0;
        end else begin
            r_hit_prev  <= bullet_hit;
            r_pending   <= w_pend_next;
            r_score     <= w_score_next;
            r_score_max <= (w_score_next == SCORE_MAX);
        end
    end

    assign w_sel   = r_scan[SCAN_BITS-1 -: 2];
    assign w_digit = r_score[{w_sel, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Free-running digit scan; anode and segments register from the same select so they switch together.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_an   <= AN_OFF;
            r_seg  <= SEG_BLANK;
        end else begin
            r_scan <= r_scan + 1'b1;
            r_an   <= AN_SEL[w_sel];
            r_seg  <= w_seg;
        end
    end

    assign score_bcd = r_score;
    assign score_max = r_score_max;
    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed self-checking bench for score_display
module tb_score_display;

    logic        clk25 = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  bullet_hit = 8'h00;
    logic [15:0] score_bcd;
    logic        score_max;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int errors = 0;

    always #20 clk25 = ~clk25;

    score_display #(
        .HIT_WIDTH (8),
        .SCAN_BITS (4),
        .PEND_BITS (4)
    ) dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .bullet_hit (bullet_hit),
        .clear      (clear),
        .score_bcd  (score_bcd),
        .score_max  (score_max),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hits(input int n);
        int          k;
        logic [8:0]  m;
        while (n > 0) begin
            k = (n >= 8) ? 8 : n;
            m = (9'd1 << k) - 9'd1;
            bullet_hit = m[7:0];
            tick();
            bullet_hit = 8'h00;
            tick(k + 1);
            n -= k;
        end
    endtask

    logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] exp_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    initial begin
        logic [3:0] prev_an;
        logic       found;
        // reset
        tick(5);
        chk("rst_score", score_bcd, 16'h0000);
        chk("rst_max", 16'(score_max), 16'h0);
        chk("rst_an", 16'(an), 16'hF);
        chk("rst_seg", 16'(seg), 16'h7F);
        chk("rst_dp", 16'(dp), 16'h1);
        rst_n = 1'b1;
        tick();
        chk("first_an", 16'(an), 16'hE);
        chk("first_seg", 16'(seg), 16'h40);
        // single hit
        bullet_hit = 8'h01;
        tick();
        bullet_hit = 8'h00;
        chk("hit_edge_k", score_bcd, 16'h0000);
        tick();
        chk("hit_edge_k1", score_bcd, 16'h0001);
        tick(2);
        bullet_hit = 8'h01;
        tick();
        bullet_hit = 8'h00;
        tick();
        chk("hit_second", score_bcd, 16'h0002);
        // clear
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_plain", score_bcd, 16'h0000);
        // burst of 8
        bullet_hit = 8'hFF;
        tick();
        bullet_hit = 8'h00;
        tick(7);
        chk("burst_e8", score_bcd, 16'h0007);
        tick();
        chk("burst_e9", score_bcd, 16'h0008);
        tick();
        chk("burst_e10", score_bcd, 16'h0008);
        // held bit counts once
        bullet_hit = 8'h04;
        tick(20);
        bullet_hit = 8'h00;
        tick(3);
        chk("hold_once", score_bcd, 16'h0009);
        // async reset mid-operation drops pending hits
        bullet_hit = 8'h07;
        tick();
        bullet_hit = 8'h00;
        #5 rst_n = 1'b0;
        #1;
        chk("async_score", score_bcd, 16'h0000);
        chk("async_an", 16'(an), 16'hF);
        chk("async_seg", 16'(seg), 16'h7F);
        tick();
        rst_n = 1'b1;
        tick(5);
        chk("async_lost", score_bcd, 16'h0000);
        // carry chain and saturation
        hits(999);
        chk("pre_0999", score_bcd, 16'h0999);
        chk("pre_0999_max", 16'(score_max), 16'h0);
        hits(1);
        chk("carry_1000", score_bcd, 16'h1000);
        hits(8998);
        chk("pre_9998", score_bcd, 16'h9998);
        chk("pre_9998_max", 16'(score_max), 16'h0);
        bullet_hit = 8'h07;
        tick();
        bullet_hit = 8'h00;
        chk("sat_edge_k", score_bcd, 16'h9998);
        tick();
        chk("sat_9999", score_bcd, 16'h9999);
        chk("sat_max_rise", 16'(score_max), 16'h1);
        tick(4);
        chk("sat_hold", score_bcd, 16'h9999);
        chk("sat_max_hold", 16'(score_max), 16'h1);
        hits(1);
        chk("sat_more", score_bcd, 16'h9999);
        // clear beats pending and a simultaneous hit
        bullet_hit = 8'h07;
        tick();
        bullet_hit = 8'h10;
        clear = 1'b1;
        tick();
        bullet_hit = 8'h00;
        clear = 1'b0;
        chk("clr_hit_score", score_bcd, 16'h0000);
        chk("clr_hit_max", 16'(score_max), 16'h0);
        tick(6);
        chk("clr_hit_after", score_bcd, 16'h0000);
        // display scan of 1234
        hits(1234);
        chk("scan_score", score_bcd, 16'h1234);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev_an = an;
            tick();
            found = (prev_an == 4'b0111) && (an == 4'b1110);
        end
        chk("scan_align", 16'(found), 16'h1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("scan_an_%0d", i), 16'(an), 16'(exp_an[i/4]));
            chk($sformatf("scan_seg_%0d", i), 16'(seg), 16'(exp_seg[i/4]));
            chk($sformatf("scan_dp_%0d", i), 16'(dp), 16'h1);
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_display.md
# score_display

Downstream consumer of the enemy controller's `bullet_hit` vector in the shooter top level. Detects each new hit, queues it, and increments a saturating 4-digit BCD score. Drives the board's multiplexed common-anode 7-segment display, so the score is visible alongside the VGA output without touching the pixel path.

## Interface
Parameters:
- `HIT_WIDTH`, 8, width of `bullet_hit`; equals `BULLET_COUNT`.
- `SCAN_BITS`, 17, width of the digit-scan counter; the top 2 bits select the digit, giving about 190 Hz per digit at 25 MHz.
- `PEND_BITS`, 4, width of the pending-hit counter; it saturates at 2^PEND_BITS−1.

Ports:
- `clk25`  in  1  25 MHz pixel clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bullet_hit`  in  HIT_WIDTH  one bit per bullet; a 0→1 transition of a bit is one hit.
- `clear`  in  1  synchronous score clear, level-sensitive, active-high.
- `score_bcd`  out  16  current score, digits {thousands, hundreds, tens, ones}.
- `score_max`  out  1  high while `score_bcd` == 16'h9999.
- `an`  out  4  digit anodes, active-low, one-hot-low.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low; held at 1 (off).

## Operation
- **Edge detect:** `hit_prev` <= `bullet_hit` every cycle. `new_hits` = popcount(`bullet_hit` & ~`hit_prev`), range 0..HIT_WIDTH.
- **Pending counter:** `drain` = (pending != 0). Next value is pending + new_hits − drain, saturated at 2^PEND_BITS−1. Overflowing hits are dropped silently.
- **Score:**
  - When `drain` is high and score != 9999, BCD increment by 1. A ones digit of 9 wraps to 0 and carries into tens, and so on through thousands.
  - At 9999 the pending counter still drains, but the score holds.
  - No digit is ever outside 0–9.
- **Clear:** when `clear` is high, pending, score and `hit_prev` all go to 0 at the next edge. Hits arriving in that cycle are discarded. Clear has priority over everything else.
- **Display:**
  - `scan` increments every cycle and wraps freely.
  - `sel` = `scan`[SCAN_BITS−1:SCAN_BITS−2]. sel 0 → ones, `an`=1110; sel 1 → tens, 1101; sel 2 → hundreds, 1011; sel 3 → thousands, 0111.
  - Leading zeros are displayed.
  - `an` and `seg` are registered from the same `sel`, so they always change on the same edge.

## Timing
- **Reset values:**
  - Internal: `hit_prev`=0, pending=0, score=16'h0000, `scan`=0.
  - Outputs: `score_max`=0, `an`=4'b1111, `seg`=7'b1111111, `dp`=1.
  - The first digit lights one edge after `rst_n` deasserts.
- **Hit latency:** a bit rising before edge k is counted at edge k (pending becomes ≥1). The score increments at edge k+1. N simultaneous new hits take N consecutive cycles to drain.
- **Continuous input:** a bit held high counts once. It must return low for at least one cycle before it can count again.
- **Saturating outputs:** `score_max` is registered and rises on the same edge the score reaches 9999.
- **Display latency:** `an`/`seg` lag `sel` by one cycle. They reflect the score value as registered at the previous edge.
- **Reset mid-operation:** async assertion forces all reset values immediately, including in-flight pending hits; pending is lost.

## Structure
- **Shared package:** the 7-segment pattern constants for 0–9 (active-low), `SEG_BLANK`, and the anode patterns for sel 0–3.
- **Sub-module `bcd_to_7seg`:** combinational 4-bit BCD → 7-bit active-low decoder. Inputs 10–15 produce `SEG_BLANK`.
- **Parent:** edge detect, pending counter, BCD incrementer, and scan/output registers.

## Test plan
- **Reset:** `rst_n`=0 for 5 cycles → `score_bcd`=0000, `an`=1111, `seg`=1111111, `dp`=1. After release, `an`=1110 and `seg`=1000000 ("0").
- **Single hit:** `bullet_hit`=8'h01 for 1 cycle → pending=1 after edge k, `score_bcd`=0001 after edge k+1. A second pulse of the same bit 3 cycles later gives 0002.
- **Burst and hold:** `bullet_hit`=8'hFF for 1 cycle → score reaches 0008 after exactly 9 edges. `bullet_hit`=8'h04 held 20 cycles → +1 only.
- **Carry chain and saturation:** preload via hits to 0999, one hit → 1000. From 9998, three hits → 9999 with `score_max`=1; pending drains to 0 and the score stays 9999.
- **Clear vs hit:** `clear`=1 in the same cycle as `bullet_hit`=8'h10 with pending=3 → score=0000 and pending=0 next edge. No later increment occurs.
- **Scan:** with score=1234 and SCAN_BITS=4, over 16 cycles `an` walks 1110/1101/1011/0111, each held 4 cycles. `seg` shows 4, 3, 2, 1 respectively, `an` and `seg` change on the same edge, and `dp` stays 1.
